// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/interrupt controller.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_PC,
    PUSH_FLAGS,
    VECTOR
  } seq_state_t;

  localparam int REG_ADDR_W = 3;

  localparam logic VEC_INT1 = 1'b0;
  localparam logic VEC_INT2 = 1'b1;

endpackage

// File: rtl/int_sequencer.sv
// Interrupt capture and entry sequencer: edge detect, pending bits, drain counter,
// push-source latch and the IDLE/DRAIN/PUSH_PC/PUSH_FLAGS/VECTOR state machine.
module int_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int INT_DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int1,
  input  logic       int2,
  input  logic       branch_taken,
  output logic       busy,
  output logic       push_pc,
  output logic       push_flags,
  output logic       push_src,
  output logic       load_vector,
  output logic       vector_sel,
  output logic [1:0] int_ack
);

  localparam int CNT_W = (INT_DRAIN_CYCLES > 1) ? $clog2(INT_DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INT_DRAIN_CYCLES - 1);

  seq_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sel_reg;
  logic             push_src_reg;
  logic [1:0]       int_in;
  logic [1:0]       int_prev_reg;
  logic [1:0]       pending_reg;
  logic [1:0]       pending_next;
  logic [1:0]       edge_det;
  logic [1:0]       served;

  assign int_in = {int2, int1};

  // A fresh edge wins over the clear, so a re-request during VECTOR is not lost.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_int
      assign edge_det[gi]     = int_in[gi] & ~int_prev_reg[gi];
      assign served[gi]       = (state_reg == VECTOR) && (sel_reg == 1'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~served[gi]) | edge_det[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_prev_reg <= 2'b00;
      pending_reg  <= 2'b00;
    end else begin
      int_prev_reg <= int_in;
      pending_reg  <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sel_reg      <= VEC_INT1;
      push_src_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            sel_reg   <= pending_reg[0] ? VEC_INT1 : VEC_INT2;
            cnt_reg   <= CNT_LOAD;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            push_src_reg <= 1'b1;
          end
          if (cnt_reg == '0) begin
            state_reg <= PUSH_PC;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        PUSH_PC:    state_reg <= PUSH_FLAGS;
        PUSH_FLAGS: state_reg <= VECTOR;
        VECTOR: begin
          push_src_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default:    state_reg <= IDLE;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign push_pc     = (state_reg == PUSH_PC);
  assign push_flags  = (state_reg == PUSH_FLAGS);
  assign load_vector = (state_reg == VECTOR);
  assign vector_sel  = load_vector & sel_reg;
  assign push_src    = push_src_reg;
  assign int_ack     = served;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: load-use detect plus priority merge of reset,
// interrupt sequence, taken branch and load-use stall onto the pipeline enables.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INT_DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  int1,
  input  logic                  int2,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  input  logic                  dec_uses_rs,
  input  logic                  dec_uses_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic                  push_pc,
  output logic                  push_flags,
  output logic                  push_src,
  output logic                  load_vector,
  output logic                  vector_sel,
  output logic [1:0]            int_ack,
  output logic                  int_busy
);

  logic       hazard;
  logic       seq_busy;
  logic       seq_push_pc;
  logic       seq_push_flags;
  logic       seq_push_src;
  logic       seq_load_vector;
  logic       seq_vector_sel;
  logic [1:0] seq_int_ack;

  int_sequencer #(
    .INT_DRAIN_CYCLES(INT_DRAIN_CYCLES)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .int1        (int1),
    .int2        (int2),
    .branch_taken(ex_branch_taken),
    .busy        (seq_busy),
    .push_pc     (seq_push_pc),
    .push_flags  (seq_push_flags),
    .push_src    (seq_push_src),
    .load_vector (seq_load_vector),
    .vector_sel  (seq_vector_sel),
    .int_ack     (seq_int_ack)
  );

  assign hazard = ex_mem_read & dec_valid &
                  ((dec_uses_rs & (dec_rs == ex_rd)) | (dec_uses_rd & (dec_rd == ex_rd)));

  // Sequencer state may still be mid-sequence in the cycle reset is asserted.
  assign int_busy    = rst_n & seq_busy;
  assign push_pc     = rst_n & seq_push_pc;
  assign push_flags  = rst_n & seq_push_flags;
  assign push_src    = rst_n & seq_push_src;
  assign load_vector = rst_n & seq_load_vector;
  assign vector_sel  = rst_n & seq_vector_sel;
  assign int_ack     = rst_n ? seq_int_ack : 2'b00;

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (!rst_n) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (seq_busy) begin
      // Front end is held and bubbled for the whole sequence; only VECTOR moves the PC.
      pc_en    = seq_load_vector;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (ex_branch_taken) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (hazard) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized plus directed bench for pipeline_ctrl against a cycle-count reference model.
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int1, int2;
  logic       dec_valid, dec_uses_rs, dec_uses_rd, ex_mem_read, ex_branch_taken;
  logic [2:0] dec_rs, dec_rd, ex_rd;
  logic       pc_en, fd_en, fd_flush, de_flush, push_pc, push_flags, push_src;
  logic       load_vector, vector_sel, int_busy;
  logic [1:0] int_ack;

  always #5 clk = ~clk;

  pipeline_ctrl #(.INT_DRAIN_CYCLES(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .int1           (int1),
    .int2           (int2),
    .dec_valid      (dec_valid),
    .dec_rs         (dec_rs),
    .dec_rd         (dec_rd),
    .dec_uses_rs    (dec_uses_rs),
    .dec_uses_rd    (dec_uses_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .pc_en          (pc_en),
    .fd_en          (fd_en),
    .fd_flush       (fd_flush),
    .de_flush       (de_flush),
    .push_pc        (push_pc),
    .push_flags     (push_flags),
    .push_src       (push_src),
    .load_vector    (load_vector),
    .vector_sel     (vector_sel),
    .int_ack        (int_ack),
    .int_busy       (int_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: interrupt sequence tracked as a position count within the sequence.
  bit [1:0] m_prev, m_pend;
  bit       m_active, m_sel, m_psrc;
  int       m_pos;

  logic [1:0] ack_log[$];
  int         busy_cycles;
  int         flags_seen;
  logic       last_push_src;

  task automatic set_idle();
    rst_n = 1'b1; dec_valid = 1'b0; dec_uses_rs = 1'b0; dec_uses_rd = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    dec_rs = 3'd0; dec_rd = 3'd0; ex_rd = 3'd0;
  endtask

  task automatic step(input string tag);
    logic       e_pc, e_fd, e_fdf, e_def, e_pp, e_pf, e_ps, e_lv, e_vs, e_busy, haz;
    logic [1:0] e_ack;
    logic [11:0] e_v, g_v;
    @(negedge clk);
    e_pc = 1'b1; e_fd = 1'b1; e_fdf = 1'b0; e_def = 1'b0;
    e_pp = 1'b0; e_pf = 1'b0; e_ps = 1'b0; e_lv = 1'b0; e_vs = 1'b0; e_busy = 1'b0;
    e_ack = 2'b00;
    haz = ex_mem_read && dec_valid &&
          ((dec_uses_rs && dec_rs == ex_rd) || (dec_uses_rd && dec_rd == ex_rd));
    if (!rst_n) begin
      e_pc = 1'b0; e_fd = 1'b0; e_fdf = 1'b1; e_def = 1'b1;
    end else if (m_active) begin
      e_busy = 1'b1; e_fdf = 1'b1; e_def = 1'b1;
      e_pp = (m_pos == D); e_pf = (m_pos == D + 1); e_lv = (m_pos == D + 2);
      e_pc = e_lv; e_ps = m_psrc;
      e_vs = e_lv & m_sel;
      if (e_lv) e_ack = m_sel ? 2'b10 : 2'b01;
    end else if (ex_branch_taken) begin
      e_fdf = 1'b1; e_def = 1'b1;
    end else if (haz) begin
      e_pc = 1'b0; e_fd = 1'b0; e_def = 1'b1;
    end
    e_v = {e_pc, e_fd, e_fdf, e_def, e_pp, e_pf, e_ps, e_lv, e_vs, e_ack, e_busy};
    g_v = {pc_en, fd_en, fd_flush, de_flush, push_pc, push_flags, push_src,
           load_vector, vector_sel, int_ack, int_busy};
    check_val(tag, 32'(g_v), 32'(e_v));
    if (int_busy) busy_cycles++;
    if (push_flags) flags_seen++;
    if (push_pc) last_push_src = push_src;
    if (int_ack != 2'b00) begin
      ack_log.push_back(int_ack);
      $display("ack %s: int_ack=%b vector_sel=%b t=%0t", tag, int_ack, vector_sel, $time);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_prev = 2'b00; m_pend = 2'b00; m_active = 1'b0; m_pos = 0; m_psrc = 1'b0;
    end else begin
      bit [1:0] lvl, edges;
      lvl = {int2, int1};
      edges = lvl & ~m_prev;
      m_prev = lvl;
      if (m_active) begin
        if (m_pos < D && ex_branch_taken) m_psrc = 1'b1;
        if (m_pos == D + 2) begin
          m_pend[m_sel] = 1'b0; m_active = 1'b0; m_psrc = 1'b0;
        end else begin
          m_pos++;
        end
      end else if (m_pend != 2'b00) begin
        m_active = 1'b1; m_pos = 0; m_sel = !m_pend[0];
      end
      m_pend |= edges;
    end
    #1;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0; int1 = 1'b0; int2 = 1'b0;
    #1;
    step("reset0");
    step("reset1");
    check_val("reset_pc_en_low", 32'(pc_en), 32'd0);
    rst_n = 1'b1;
    step("release");
    check_val("release_pc_en", 32'(pc_en), 32'd1);

    // Load-use: one stall cycle, then free.
    ex_mem_read = 1'b1; ex_rd = 3'd3; dec_valid = 1'b1; dec_rs = 3'd3; dec_uses_rs = 1'b1;
    step("loaduse");
    ex_mem_read = 1'b0;
    step("loaduse_after");
    // Same hazard with a taken branch.
    ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
    step("loaduse_branch");
    set_idle();
    step("idle0");

    // int2 alone.
    busy_cycles = 0; ack_log.delete();
    int2 = 1'b1;
    for (int i = 0; i < 10; i++) step("int2_seq");
    check_val("int2_busy_cycles", 32'(busy_cycles), 32'd6);
    check_val("int2_ack_count", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) check_val("int2_ack_val", 32'(ack_log[0]), 32'd2);
    int2 = 1'b0;
    step("int2_low");

    // Simultaneous int1 and int2.
    busy_cycles = 0; ack_log.delete();
    int1 = 1'b1; int2 = 1'b1;
    for (int i = 0; i < 16; i++) step("both_seq");
    check_val("both_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      check_val("both_first_ack", 32'(ack_log[0]), 32'd1);
      check_val("both_second_ack", 32'(ack_log[1]), 32'd2);
    end
    check_val("both_busy_cycles", 32'(busy_cycles), 32'd12);
    int1 = 1'b0; int2 = 1'b0;
    step("both_low");

    // Taken branch in the second DRAIN cycle.
    last_push_src = 1'b0;
    int1 = 1'b1;
    step("br_edge");
    step("br_idle");
    step("br_drain1");
    ex_branch_taken = 1'b1;
    step("br_drain2");
    ex_branch_taken = 1'b0;
    for (int i = 0; i < 5; i++) step("br_seq");
    check_val("br_push_src_at_push", 32'(last_push_src), 32'd1);
    check_val("br_push_src_after", 32'(push_src), 32'd0);
    int1 = 1'b0;
    step("br_low");

    // Reset during PUSH_PC aborts the sequence.
    ack_log.delete(); flags_seen = 0;
    int1 = 1'b1;
    step("rst_edge");
    for (int i = 0; i < 4; i++) step("rst_pre");
    check_val("rst_in_push_pc", 32'(push_pc), 32'd1);
    rst_n = 1'b0; int1 = 1'b0;
    step("rst_during_push");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("rst_after");
    check_val("rst_no_ack", 32'(ack_log.size()), 32'd0);
    check_val("rst_no_flags", 32'(flags_seen), 32'd0);
    check_val("rst_pc_en", 32'(pc_en), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rst_n           = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 24) == 0) int1 = ~int1;
      if ($urandom_range(0, 24) == 0) int2 = ~int2;
      dec_valid       = ($urandom_range(0, 3) != 0);
      dec_uses_rs     = $urandom_range(0, 1);
      dec_uses_rd     = $urandom_range(0, 1);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      dec_rs          = 3'($urandom_range(0, 3));
      dec_rd          = 3'($urandom_range(0, 3));
      ex_rd           = 3'($urandom_range(0, 3));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
